// File: rtl/sky130_ef_sc_hd__pwrseq_ctrl.sv
// rtl/sky130_ef_sc_hd__pwrseq_ctrl.sv - staggered header-switch power sequencer with isolation and power-good
module sky130_ef_sc_hd__pwrseq_ctrl #(
    parameter int NUM_ROWS       = 8,
    parameter int STAGGER_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 16
) (
`ifdef USE_POWER_PINS
    input  logic                VPWR,
    input  logic                VGND,
    input  logic                VPB,
    input  logic                VNB,
`endif
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PWR_REQ,
    output logic [NUM_ROWS-1:0] SW_EN,
    output logic                ISO_EN,
    output logic                PWR_GOOD,
    output logic                BUSY
);

`ifndef USE_POWER_PINS
    supply1 VPWR;
    supply1 VPB;
    supply0 VGND;
    supply0 VNB;
`endif

    logic unused_pwr;
    assign unused_pwr = VPWR & VPB & ~VGND & ~VNB;

    localparam int MAX_CNT = (STAGGER_CYCLES > SETTLE_CYCLES) ? STAGGER_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0]    STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SET_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ISO_LAST  = CNT_W'(1);
    localparam logic [NUM_ROWS-1:0] ALL_ONES  = {NUM_ROWS{1'b1}};

    typedef enum logic [2:0] {
        OFF,
        RAMP_UP,
        SETTLE,
        ON,
        ISOLATE,
        RAMP_DOWN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_ROWS-1:0] sw_q, sw_d;
    logic                iso_q, iso_d;
    logic                pg_q, pg_d;
    logic                busy_q, busy_d;
    logic [NUM_ROWS-1:0] sw_dn;
    logic                step_down;

    // Thermometer code: dropping the highest row is a right shift.
    assign sw_dn = sw_q >> 1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        sw_d      = sw_q;
        step_down = 1'b0;

        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (PWR_REQ) begin
                    state_d = RAMP_UP;
                    sw_d    = NUM_ROWS'(1);
                end
            end
            RAMP_UP: begin
                if (!PWR_REQ) begin
                    step_down = 1'b1;
                end else if (cnt_q == STAG_LAST) begin
                    cnt_d = '0;
                    if (sw_q == ALL_ONES) begin
                        state_d = SETTLE;
                    end else begin
                        sw_d = (sw_q << 1) | NUM_ROWS'(1);
                    end
                end
            end
            SETTLE: begin
                if (!PWR_REQ) begin
                    step_down = 1'b1;
                end else if (cnt_q == SET_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                cnt_d = '0;
                if (!PWR_REQ) begin
                    state_d = ISOLATE;
                end
            end
            ISOLATE: begin
                if (cnt_q == ISO_LAST) begin
                    step_down = 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (cnt_q == STAG_LAST) begin
                    step_down = 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
                sw_d    = '0;
            end
        endcase

        // Shared by abort, end of isolation and each ramp-down step.
        if (step_down) begin
            sw_d    = sw_dn;
            cnt_d   = '0;
            state_d = (sw_dn == '0) ? OFF : RAMP_DOWN;
        end

        iso_d  = (state_d != ON);
        pg_d   = (state_d == ON);
        busy_d = (state_d != ON) && (state_d != OFF);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= OFF;
            cnt_q   <= '0;
            sw_q    <= '0;
            iso_q   <= 1'b1;
            pg_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            iso_q   <= iso_d;
            pg_q    <= pg_d;
            busy_q  <= busy_d;
        end
    end

    assign SW_EN    = sw_q;
    assign ISO_EN   = iso_q;
    assign PWR_GOOD = pg_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_sky130_ef_sc_hd__pwrseq_ctrl.sv
// tb/tb_sky130_ef_sc_hd__pwrseq_ctrl.sv - directed bench for default and minimal-parameter sequencers
module tb_sky130_ef_sc_hd__pwrseq_ctrl;

    logic       clk;
    logic       rst0, req0, iso0, pg0, busy0;
    logic [7:0] sw0;
    logic       rst1, req1, iso1, pg1, busy1;
    logic [0:0] sw1;

    int checks = 0;
    int errors = 0;
    logic pg_watch = 1'b0;
    logic pg_seen  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sky130_ef_sc_hd__pwrseq_ctrl dut0 (
        .CLK(clk), .RESET(rst0), .PWR_REQ(req0),
        .SW_EN(sw0), .ISO_EN(iso0), .PWR_GOOD(pg0), .BUSY(busy0)
    );

    sky130_ef_sc_hd__pwrseq_ctrl #(
        .NUM_ROWS(1), .STAGGER_CYCLES(1), .SETTLE_CYCLES(1)
    ) dut1 (
        .CLK(clk), .RESET(rst1), .PWR_REQ(req1),
        .SW_EN(sw1), .ISO_EN(iso1), .PWR_GOOD(pg1), .BUSY(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [7:0] t0;
        t0 = sw0 + 8'd1;
        check_eq("therm0", 32'((t0 & sw0) == 8'd0), 32'd1);
        if (pg_watch && pg0) pg_seen = 1'b1;
    end

    initial begin
        rst0 = 1'b1; req0 = 1'b0;
        rst1 = 1'b1; req1 = 1'b0;
        @(negedge clk);
        step(2);
        rst0 = 1'b0;
        step(2);
        check_eq("rst_sw",   32'(sw0),   32'h00);
        check_eq("rst_iso",  32'(iso0),  32'd1);
        check_eq("rst_pg",   32'(pg0),   32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);

        // Power-up: edge 0 samples the request.
        req0 = 1'b1;
        step(1);
        check_eq("up_e0_sw",   32'(sw0),   32'h01);
        check_eq("up_e0_busy", 32'(busy0), 32'd1);
        check_eq("up_e0_iso",  32'(iso0),  32'd1);
        step(4);
        check_eq("up_e4_sw",   32'(sw0),   32'h03);
        step(23);
        check_eq("up_e27_sw",  32'(sw0),   32'h7F);
        step(1);
        check_eq("up_e28_sw",  32'(sw0),   32'hFF);
        step(19);
        check_eq("up_e47_busy", 32'(busy0), 32'd1);
        check_eq("up_e47_pg",   32'(pg0),   32'd0);
        step(1);
        check_eq("on_pg",   32'(pg0),   32'd1);
        check_eq("on_iso",  32'(iso0),  32'd0);
        check_eq("on_busy", 32'(busy0), 32'd0);
        check_eq("on_sw",   32'(sw0),   32'hFF);
        step(3);
        check_eq("on_hold_pg", 32'(pg0), 32'd1);

        // Power-down from ON at edge E, re-request at E+10.
        req0 = 1'b0;
        step(1);
        check_eq("dn_e_pg",   32'(pg0),   32'd0);
        check_eq("dn_e_iso",  32'(iso0),  32'd1);
        check_eq("dn_e_busy", 32'(busy0), 32'd1);
        check_eq("dn_e_sw",   32'(sw0),   32'hFF);
        step(1);
        check_eq("dn_e1_sw",  32'(sw0),   32'hFF);
        step(1);
        check_eq("dn_e2_sw",  32'(sw0),   32'h7F);
        step(7);
        check_eq("dn_e9_sw",  32'(sw0),   32'h3F);
        req0 = 1'b1;
        step(1);
        check_eq("dn_e10_sw",   32'(sw0),   32'h1F);
        check_eq("dn_e10_busy", 32'(busy0), 32'd1);
        step(19);
        check_eq("dn_e29_sw",   32'(sw0),   32'h01);
        step(1);
        check_eq("dn_e30_sw",   32'(sw0),   32'h00);
        check_eq("dn_e30_busy", 32'(busy0), 32'd0);
        check_eq("dn_e30_iso",  32'(iso0),  32'd1);
        step(1);
        check_eq("re_e31_sw",   32'(sw0),   32'h01);
        check_eq("re_e31_busy", 32'(busy0), 32'd1);

        // Abort during ramp-up at edge 9.
        req0 = 1'b0; rst0 = 1'b1;
        step(1);
        check_eq("rst2_sw", 32'(sw0), 32'h00);
        rst0 = 1'b0; req0 = 1'b1; pg_watch = 1'b1;
        step(1);
        check_eq("ab_e0_sw", 32'(sw0), 32'h01);
        step(8);
        check_eq("ab_e8_sw", 32'(sw0), 32'h07);
        req0 = 1'b0;
        step(1);
        check_eq("ab_e9_sw",   32'(sw0),   32'h03);
        check_eq("ab_e9_busy", 32'(busy0), 32'd1);
        step(3);
        check_eq("ab_e12_sw",  32'(sw0),   32'h03);
        step(1);
        check_eq("ab_e13_sw",  32'(sw0),   32'h01);
        step(3);
        check_eq("ab_e16_sw",  32'(sw0),   32'h01);
        step(1);
        check_eq("ab_e17_sw",   32'(sw0),   32'h00);
        check_eq("ab_e17_busy", 32'(busy0), 32'd0);
        step(2);
        check_eq("ab_off_sw", 32'(sw0), 32'h00);
        pg_watch = 1'b0;
        check_eq("ab_pg_never", 32'(pg_seen), 32'd0);

        // Reset in SETTLE at edge 40.
        req0 = 1'b1;
        step(1);
        step(39);
        check_eq("rs_e39_sw",   32'(sw0),   32'hFF);
        check_eq("rs_e39_busy", 32'(busy0), 32'd1);
        rst0 = 1'b1;
        step(1);
        check_eq("rs_e40_sw",   32'(sw0),   32'h00);
        check_eq("rs_e40_iso",  32'(iso0),  32'd1);
        check_eq("rs_e40_pg",   32'(pg0),   32'd0);
        check_eq("rs_e40_busy", 32'(busy0), 32'd0);
        rst0 = 1'b0; req0 = 1'b0;

        // Minimal configuration: one row, one-cycle stagger and settle.
        rst1 = 1'b0;
        step(1);
        check_eq("m_rst_sw",  32'(sw1),  32'd0);
        check_eq("m_rst_iso", 32'(iso1), 32'd1);
        req1 = 1'b1;
        step(1);
        check_eq("m_e0_sw",   32'(sw1),   32'd1);
        check_eq("m_e0_busy", 32'(busy1), 32'd1);
        step(1);
        check_eq("m_e1_pg",   32'(pg1),   32'd0);
        check_eq("m_e1_busy", 32'(busy1), 32'd1);
        step(1);
        check_eq("m_e2_pg",   32'(pg1),   32'd1);
        check_eq("m_e2_iso",  32'(iso1),  32'd0);
        check_eq("m_e2_busy", 32'(busy1), 32'd0);
        req1 = 1'b0;
        step(1);
        check_eq("m_de_pg",  32'(pg1),  32'd0);
        check_eq("m_de_iso", 32'(iso1), 32'd1);
        check_eq("m_de_sw",  32'(sw1),  32'd1);
        step(1);
        check_eq("m_de1_sw", 32'(sw1),  32'd1);
        step(1);
        check_eq("m_de2_sw",   32'(sw1),   32'd0);
        check_eq("m_de2_busy", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
